am_sdr_demod_sched: RTL

//   Scheduler for the 1-bit AM SDR demodulation datapath. Generates the CIC decimation strobe,

---
 rtl/am_sdr_demod_sched.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/am_sdr_demod_sched.sv
// rtl/am_sdr_demod_sched.sv - CIC decimation strobe and shared-multiplier I^2+Q^2 scheduler
// Optional peak-hold of the envelope power is enabled by defining AM_SDR_SCHED_PEAK_EN.
module am_sdr_demod_sched #(
    parameter int DATA_W    = 16,
    parameter int DECIM_W   = 10,
    parameter int DECIM_DEF = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [DECIM_W-1:0]    cfg_decim,
    output logic                  dec_stb,
    input  logic                  cic_valid,
    input  logic [DATA_W-1:0]     i_in,
    input  logic [DATA_W-1:0]     q_in,
    output logic [DATA_W-1:0]     mul_a,
    output logic [DATA_W-1:0]     mul_b,
    input  logic [2*DATA_W-1:0]   mul_p,
    output logic [2*DATA_W-1:0]   mag_out,
    output logic                  mag_valid,
    output logic                  overrun,
    output logic [2*DATA_W-1:0]   peak_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_I = 2'd1,
        SQ_Q = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [DECIM_W-1:0] RATIO_MIN = DECIM_W'(4);
    localparam logic [DECIM_W-1:0] RATIO_RST = DECIM_W'(DECIM_DEF);

    logic [DECIM_W-1:0]  ratio;
    logic [DECIM_W-1:0]  count;
    logic                count_last;
    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   i_r;
    logic [DATA_W-1:0]   q_r;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] sum;

    assign count_last = (count == ratio - DECIM_W'(1));
    assign dec_stb    = count_last && !cfg_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ratio <= RATIO_RST;
            count <= '0;
        end else if (cfg_we) begin
            ratio <= (cfg_decim < RATIO_MIN) ? RATIO_MIN : cfg_decim;
            count <= '0;
        end else if (count_last) begin
            count <= '0;
        end else begin
            count <= count + DECIM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mul_a      = '0;
        mul_b      = '0;
        case (state)
            IDLE: begin
                if (cic_valid) begin
                    state_next = SQ_I;
                end
            end
            SQ_I: begin
                mul_a      = i_r;
                mul_b      = i_r;
                state_next = SQ_Q;
            end
            SQ_Q: begin
                mul_a      = q_r;
                mul_b      = q_r;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A square is never negative, so the product can be summed as unsigned.
    assign sum       = acc + mul_p;
    assign mag_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_r     <= '0;
            q_r     <= '0;
            acc     <= '0;
            mag_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cic_valid) begin
                        i_r <= i_in;
                        q_r <= q_in;
                    end
                end
                SQ_I: acc <= mul_p;
                SQ_Q: begin
                    acc     <= sum;
                    mag_out <= sum;
                end
                default: ;
            endcase
        end
    end

    // A sample arriving while the FSM is busy is lost; a concurrent loss outranks the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (cic_valid && (state != IDLE)) begin
            overrun <= 1'b1;
        end else if (cfg_we) begin
            overrun <= 1'b0;
        end
    end

`ifdef AM_SDR_SCHED_PEAK_EN
    logic [2*DATA_W-1:0] peak_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_r <= '0;
        end else if (cfg_we) begin
            peak_r <= '0;
        end else if ((state == SQ_Q) && (sum > peak_r)) begin
            peak_r <= sum;
        end
    end

    assign peak_out = peak_r;
`else
    assign peak_out = '0;
`endif

endmodule
